ras_ctrl: RTL and testbench

- Fetch-stage predecoder sitting directly upstream of the return address stack.
- Scans each accepted fetch group for MIPS call and return instructions, and drives the stack's push/pop requests and push data.
- Tracks branch delay slots, including the case where the delay slot falls into the next fetch group.
- Issues a registered return-target redirect to the PC generator, using the stack top.

---
 rtl/ras_ctrl.sv | 148 ++++++++++++++
 tb/tb_ras_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// Return-address-stack predecoder: finds MIPS calls/returns in each fetch group, drives push/pop,
// tracks delay slots and issues a registered return redirect. Optional macro: RAS_CTRL_BRANCH_LINK_EN.
package ras_ctrl_pkg;
   typedef logic [31:0] virt_t;
   typedef struct packed {
      virt_t data;
      logic  valid;
   } ras_t;
endpackage

module ras_ctrl
   import ras_ctrl_pkg::*;
#(
   parameter int FETCH_NUM = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [FETCH_NUM-1:0]       fetch_valid,
   input  logic                       fetch_ready,
   input  virt_t                      fetch_pc,
   input  logic [FETCH_NUM-1:0][31:0] fetch_instr,
   input  ras_t                       ras_top,
   output logic                       push_req,
   output logic                       pop_req,
   output virt_t                      push_data,
   output logic                       redirect_valid,
   output virt_t                      redirect_pc
);
   localparam int IW = (FETCH_NUM > 1) ? $clog2(FETCH_NUM) : 1;

   typedef enum logic {IDLE, WAIT_DS} state_t;

   state_t               state_reg, state_next;
   virt_t                saved_target_reg;
   logic                 saved_tvalid_reg;
   logic                 redirect_valid_reg;
   virt_t                redirect_pc_reg;

   logic [FETCH_NUM-1:0] is_call, is_ret, is_last;
   logic                 hit, hit_call, hit_last;
   logic [IW-1:0]        hit_idx;
   logic                 kill, accept, scan, ret_now;

   generate
      for (genvar gi = 0; gi < FETCH_NUM; gi++) begin : g_dec
         logic [5:0] op, funct;
         logic [4:0] rs, rd;
         logic       link_branch;
         logic       unused_fields;

         assign op    = fetch_instr[gi][31:26];
         assign rs    = fetch_instr[gi][25:21];
         assign rd    = fetch_instr[gi][15:11];
         assign funct = fetch_instr[gi][5:0];
`ifdef RAS_CTRL_BRANCH_LINK_EN
         // BLTZAL/BGEZAL link unconditionally, so they always count as calls
         assign link_branch = (op == 6'b000001) &&
                              ((fetch_instr[gi][20:16] == 5'b10000) ||
                               (fetch_instr[gi][20:16] == 5'b10001));
`else
         assign link_branch = 1'b0;
`endif
         assign unused_fields = ^{fetch_instr[gi][20:16], fetch_instr[gi][10:6]};

         assign is_call[gi] = fetch_valid[gi] &&
                              ((op == 6'b000011) ||
                               ((op == 6'b000000) && (funct == 6'b001001) && (rd == 5'd31)) ||
                               link_branch);
         assign is_ret[gi]  = fetch_valid[gi] &&
                              (op == 6'b000000) && (funct == 6'b001000) && (rs == 5'd31);

         if (gi == FETCH_NUM - 1) begin : g_tail
            assign is_last[gi] = 1'b1;
         end else begin : g_mid
            assign is_last[gi] = !fetch_valid[gi+1];
         end
      end
   endgenerate

   // Lowest-addressed call/return wins; younger slots are discarded after the delay slot
   always_comb begin
      hit      = 1'b0;
      hit_call = 1'b0;
      hit_last = 1'b0;
      hit_idx  = '0;
      for (int i = FETCH_NUM - 1; i >= 0; i--) begin
         if (is_call[i] || is_ret[i]) begin
            hit      = 1'b1;
            hit_call = is_call[i];
            hit_last = is_last[i];
            hit_idx  = IW'(i);
         end
      end
   end

   assign kill    = rst || flush;
   assign accept  = fetch_valid[0] && fetch_ready && !kill;
   assign scan    = accept && (state_reg == IDLE);
   assign ret_now = scan && hit && !hit_call;

   always_ff @(posedge clk) begin
      if (kill) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (ret_now && hit_last) state_next = WAIT_DS;
         WAIT_DS: if (accept)              state_next = IDLE;
         default:                          state_next = IDLE;
      endcase
   end

   always_comb begin
      push_req  = scan && hit && hit_call;
      pop_req   = ret_now;
      push_data = fetch_pc + (virt_t'(hit_idx) << 2) + 32'd8;
   end

   always_ff @(posedge clk) begin
      if (kill) begin
         saved_target_reg   <= '0;
         saved_tvalid_reg   <= 1'b0;
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= '0;
      end else begin
         redirect_valid_reg <= 1'b0;
         if (ret_now) begin
            saved_target_reg <= ras_top.data;
            saved_tvalid_reg <= ras_top.valid;
            if (!hit_last) begin
               redirect_valid_reg <= ras_top.valid;
               if (ras_top.valid) redirect_pc_reg <= ras_top.data;
            end
         end
         // The accepted group in WAIT_DS carries the delay slot; fire the saved target now
         if ((state_reg == WAIT_DS) && accept) begin
            redirect_valid_reg <= saved_tvalid_reg;
            if (saved_tvalid_reg) redirect_pc_reg <= saved_target_reg;
         end
      end
   end

   assign redirect_valid = redirect_valid_reg;
   assign redirect_pc    = redirect_pc_reg;
endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: directed test-plan cases then random groups against a rule-level model.
module tb_ras_ctrl;
   import ras_ctrl_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic [1:0]       fetch_valid = '0;
   logic             fetch_ready = 1'b0;
   virt_t            fetch_pc = '0;
   logic [1:0][31:0] fetch_instr = '0;
   ras_t             ras_top = '0;
   logic             push_req, pop_req, redirect_valid;
   virt_t            push_data, redirect_pc;

   always #5 clk = ~clk;

   ras_ctrl #(.FETCH_NUM(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .ras_top(ras_top),
      .push_req(push_req), .pop_req(pop_req), .push_data(push_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   typedef struct {
      bit          push;
      bit          pop;
      logic [31:0] pdata;
      bit          chk_r;
      bit          rv;
      logic [31:0] rpc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Model: a return whose delay slot is still owed, plus what the redirect outputs show next cycle
   bit          m_owed = 0;
   bit          m_sv = 0;
   logic [31:0] m_st = '0;
   bit          m_rv = 0;
   logic [31:0] m_rpc = '0;
   bit          m_known = 0;

   localparam logic [31:0] NOP = 32'h0;

   function automatic logic [31:0] enc_jal(input logic [25:0] t);
      return {6'b000011, t};
   endfunction
   function automatic logic [31:0] enc_jalr(input logic [4:0] rs, input logic [4:0] rd);
      return {6'b000000, rs, 5'd0, rd, 5'd0, 6'b001001};
   endfunction
   function automatic logic [31:0] enc_jr(input logic [4:0] rs);
      return {6'b000000, rs, 15'd0, 6'b001000};
   endfunction
   function automatic logic [31:0] enc_bal(input logic [4:0] rt, input logic [15:0] imm);
      return {6'b000001, 5'd4, rt, imm};
   endfunction

   function automatic bit m_is_call(input logic [31:0] w);
      bit c;
      c = (w[31:26] == 6'b000011) ||
          ((w[31:26] == 6'b000000) && (w[5:0] == 6'b001001) && (w[15:11] == 5'd31));
`ifdef RAS_CTRL_BRANCH_LINK_EN
      c = c || ((w[31:26] == 6'b000001) && ((w[20:16] == 5'b10000) || (w[20:16] == 5'b10001)));
`endif
      return c;
   endfunction
   function automatic bit m_is_ret(input logic [31:0] w);
      return (w[31:26] == 6'b000000) && (w[5:0] == 6'b001000) && (w[25:21] == 5'd31);
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, want, $time);
      end
   endfunction

   task automatic step(input logic [1:0] fv, input bit rdy, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] td, input bit tv, input bit fl, input bit rs);
      exp_t        e;
      logic [31:0] ins [2];
      bit          done;
      ins[0] = i0;
      ins[1] = i1;
      fetch_valid = fv; fetch_ready = rdy; fetch_pc = pc;
      fetch_instr[0] = i0; fetch_instr[1] = i1;
      ras_top.data = td; ras_top.valid = tv;
      flush = fl; rst = rs;

      e.push = 0; e.pop = 0; e.pdata = '0;
      e.chk_r = m_known; e.rv = m_rv; e.rpc = m_rpc;
      m_rv = 0;
      if (fl || rs) begin
         m_owed = 0; m_sv = 0; m_st = '0; m_rpc = '0; m_known = 1;
      end else if (fv[0] && rdy) begin
         if (m_owed) begin
            m_owed = 0;
            m_rv   = m_sv;
            if (m_sv) m_rpc = m_st;
         end else begin
            done = 0;
            for (int k = 0; k < 2; k++) begin
               if (!done && fv[k]) begin
                  if (m_is_call(ins[k])) begin
                     e.push = 1; e.pdata = pc + 32'(4 * k) + 32'd8; done = 1;
                  end else if (m_is_ret(ins[k])) begin
                     e.pop = 1; done = 1;
                     if ((k == 1) || !fv[1]) begin
                        m_owed = 1; m_sv = tv; m_st = td;
                     end else begin
                        m_rv = tv;
                        if (tv) m_rpc = td;
                     end
                  end
               end
            end
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 1'b1, 32'h0, NOP, NOP, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rand_instr();
      case ($urandom_range(0, 8))
         0: return enc_jal(26'($urandom));
         1: return enc_jalr(5'($urandom), 5'd31);
         2: return enc_jalr(5'($urandom), 5'($urandom));
         3: return enc_jr(5'd31);
         4: return enc_jr(5'($urandom));
         5: return enc_bal(5'b10001, 16'($urandom));
         6: return enc_bal(5'b10000, 16'($urandom));
         7: return NOP;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: one expectation per cycle, checked mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("push_req", 32'(push_req), 32'(e.push));
            chk("pop_req", 32'(pop_req), 32'(e.pop));
            if (e.push) chk("push_data", push_data, e.pdata);
            if (e.chk_r) begin
               chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
               chk("redirect_pc", redirect_pc, e.rpc);
            end
            if (e.push || e.pop || e.rv)
               $display("txn t=%0t push=%0b data=%h pop=%0b redirect=%0b pc=%h",
                        $time, push_req, push_data, pop_req, redirect_valid, redirect_pc);
         end
      end
   end

   initial begin
      logic [1:0]  fv;
      logic [31:0] pc;
      @(posedge clk);
      #1;
      step(2'b11, 1'b1, 32'h0, NOP, NOP, 32'h0, 1'b0, 1'b0, 1'b1);
      step(2'b11, 1'b1, 32'h0, NOP, NOP, 32'h0, 1'b0, 1'b0, 1'b1);
      idle(2);
      // call push
      step(2'b11, 1'b1, 32'h8000_1000, enc_jal(26'h40), NOP, 32'h0, 1'b0, 1'b0, 1'b0);
      // return, delay slot in group
      step(2'b11, 1'b1, 32'h8000_1100, enc_jr(5'd31), NOP, 32'h8000_1008, 1'b1, 1'b0, 1'b0);
      idle(2);
      // return, delay slot in next group, with stalls in between
      step(2'b11, 1'b1, 32'h8000_2000, NOP, enc_jr(5'd31), 32'h8000_ABC0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(2'b11, 1'b0, 32'h8000_2008, enc_jal(26'h1), NOP, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 32'h8000_2008, enc_jal(26'h1), enc_jr(5'd31), 32'h1234_5678, 1'b1, 1'b0, 1'b0);
      idle(2);
      // non-return, ordering, invalid stack top
      step(2'b11, 1'b1, 32'h8000_3000, enc_jr(5'd5), NOP, 32'h5555_0000, 1'b1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 32'h8000_3100, enc_jal(26'h2), enc_jr(5'd31), 32'h6666_0000, 1'b1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 32'h8000_3200, enc_jr(5'd31), NOP, 32'h7777_0000, 1'b0, 1'b0, 1'b0);
      idle(2);
      // flush while owing a delay slot, then a normally scanned group
      step(2'b11, 1'b1, 32'h8000_4000, NOP, enc_jr(5'd31), 32'h8888_0000, 1'b1, 1'b0, 1'b0);
      step(2'b00, 1'b0, 32'h0, NOP, NOP, 32'h0, 1'b0, 1'b1, 1'b0);
      step(2'b11, 1'b1, 32'h8000_5000, enc_jal(26'h3), NOP, 32'h9999_0000, 1'b1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 32'h8000_5100, enc_jal(26'h3), NOP, 32'h9999_0000, 1'b1, 1'b1, 1'b0);
      idle(1);
      // linking branch and address wrap
      step(2'b11, 1'b1, 32'h8000_3000, enc_bal(5'b10001, 16'h10), NOP, 32'h0, 1'b0, 1'b0, 1'b0);
      step(2'b11, 1'b1, 32'hFFFF_FFF8, NOP, enc_jal(26'h4), 32'h0, 1'b0, 1'b0, 1'b0);
      step(2'b01, 1'b1, 32'hFFFF_FFFC, enc_jalr(5'd2, 5'd31), NOP, 32'h0, 1'b0, 1'b0, 1'b0);
      idle(2);

      for (int n = 0; n < 1500; n++) begin
         case ($urandom_range(0, 5))
            0:       fv = 2'b00;
            1:       fv = 2'b01;
            default: fv = 2'b11;
         endcase
         pc = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 3) * 4))
                                           : ($urandom & 32'hFFFF_FFFC);
         step(fv, ($urandom_range(0, 3) != 0), pc, rand_instr(), rand_instr(),
              $urandom, 1'($urandom), ($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0));
      end
      idle(1);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
